// File: rtl/dispatch_pkg.sv
// Shared definitions for the parametrised dispatch unit: control codes,
// instruction classes and the layout of the flat reservation-station entry space.
package dispatch_pkg;

    localparam logic [1:0] CTRL_BUBBLE = 2'b00;
    localparam logic [1:0] CTRL_CX     = 2'b01;
    localparam logic [1:0] CTRL_FP     = 2'b10;
    localparam logic [1:0] CTRL_SP     = 2'b11;

    typedef enum logic [1:0] {
        CLS_NONE = 2'b00,
        CLS_CX   = 2'b01,
        CLS_FP   = 2'b10,
        CLS_SP   = 2'b11
    } rs_class_e;

    function automatic rs_class_e ctrl_class(input logic [1:0] ctrl);
        rs_class_e cls;
        case (ctrl)
            CTRL_CX: cls = CLS_CX;
            CTRL_FP: cls = CLS_FP;
            CTRL_SP: cls = CLS_SP;
            default: cls = CLS_NONE;
        endcase
        return cls;
    endfunction

    // Entry space is laid out complex, then simple, then FP.
    function automatic int cx_base();
        return 0;
    endfunction

    function automatic int sp_base(input int n_cx);
        return n_cx;
    endfunction

    function automatic int fp_base(input int n_cx, input int n_sp);
        return n_cx + n_sp;
    endfunction

    function automatic int entry_w(input int nt);
        return (nt > 1) ? $clog2(nt) : 1;
    endfunction

endpackage

// File: rtl/rs_pick.sv
// Combinational free-entry picker: returns the preferred available RS entry
// for one instruction class within the flat entry space.
module rs_pick
    import dispatch_pkg::*;
#(
    parameter int  N_CX = 2,
    parameter int  N_SP = 2,
    parameter int  N_FP = 2,
    localparam int NT   = N_CX + N_SP + N_FP,
    localparam int EW   = entry_w(NT)
) (
    input  logic [1:0]    control,
    input  logic [NT-1:0] avail,
    output logic          found,
    output logic [EW-1:0] idx,
    output logic [NT-1:0] onehot
);

    localparam int CX_B = cx_base();
    localparam int SP_B = sp_base(N_CX);
    localparam int FP_B = fp_base(N_CX, N_SP);
    localparam logic [NT-1:0] ONE = {{(NT-1){1'b0}}, 1'b1};

    rs_class_e     cls_s;
    logic          cx_hit_s;
    logic          sp_hit_s;
    logic          fp_hit_s;
    logic [EW-1:0] cx_idx_s;
    logic [EW-1:0] sp_idx_s;
    logic [EW-1:0] fp_idx_s;

    // Per-class scans; ascending order with override leaves the highest free entry.
    always_comb begin
        cx_hit_s = 1'b0;
        cx_idx_s = '0;
        sp_hit_s = 1'b0;
        sp_idx_s = '0;
        fp_hit_s = 1'b0;
        fp_idx_s = '0;
        for (int i = 0; i < N_CX; i++) begin
            cx_idx_s = avail[CX_B + i] ? EW'(CX_B + i) : cx_idx_s;
            cx_hit_s = cx_hit_s | avail[CX_B + i];
        end
        for (int i = 0; i < N_SP; i++) begin
            sp_idx_s = avail[SP_B + i] ? EW'(SP_B + i) : sp_idx_s;
            sp_hit_s = sp_hit_s | avail[SP_B + i];
        end
        for (int i = 0; i < N_FP; i++) begin
            fp_idx_s = avail[FP_B + i] ? EW'(FP_B + i) : fp_idx_s;
            fp_hit_s = fp_hit_s | avail[FP_B + i];
        end
    end

    // Class selection; simple instructions fall back to complex entries.
    always_comb begin
        cls_s = ctrl_class(control);
        case (cls_s)
            CLS_CX: begin
                found = cx_hit_s;
                idx   = cx_idx_s;
            end
            CLS_SP: begin
                found = sp_hit_s | cx_hit_s;
                idx   = sp_hit_s ? sp_idx_s : cx_idx_s;
            end
            CLS_FP: begin
                found = fp_hit_s;
                idx   = fp_idx_s;
            end
            default: begin
                found = 1'b0;
                idx   = '0;
            end
        endcase
        onehot = found ? (ONE << idx) : '0;
    end

endmodule

// File: rtl/dispatch_unit_param.sv
// Registered 2-wide in-order dispatcher: holds two decoded instructions and
// writes each into a free reservation-station entry one cycle later.
module dispatch_unit_param
    import dispatch_pkg::*;
#(
    parameter int  INST_W = 78,
    parameter int  N_CX   = 2,
    parameter int  N_SP   = 2,
    parameter int  N_FP   = 2,
    localparam int NT     = N_CX + N_SP + N_FP,
    localparam int EW     = entry_w(NT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid_a,
    input  logic [INST_W-1:0] in_inst_a,
    input  logic              in_valid_b,
    input  logic [INST_W-1:0] in_inst_b,
    output logic              in_ready,
    input  logic [NT-1:0]     rs_empty,
    output logic              out_a_valid,
    output logic [EW-1:0]     out_a_entry,
    output logic [INST_W-3:0] out_a_data,
    output logic              out_b_valid,
    output logic [EW-1:0]     out_b_entry,
    output logic [INST_W-3:0] out_b_data,
    output logic              stall_a,
    output logic              stall_b,
    output logic [15:0]       stall_cnt
);

    localparam int PW = INST_W - 2;

    logic              h0_valid_r;
    logic              h1_valid_r;
    logic [INST_W-1:0] h0_inst_r;
    logic [INST_W-1:0] h1_inst_r;
    logic [NT-1:0]     pend_r;
    logic              out_a_valid_r;
    logic [EW-1:0]     out_a_entry_r;
    logic [PW-1:0]     out_a_data_r;
    logic              out_b_valid_r;
    logic [EW-1:0]     out_b_entry_r;
    logic [PW-1:0]     out_b_data_r;
    logic              stall_a_r;
    logic              stall_b_r;
    logic [15:0]       stall_cnt_r;

    logic [NT-1:0]     avail0_s;
    logic [NT-1:0]     avail1_s;
    logic [NT-1:0]     oh0_s;
    logic [NT-1:0]     oh1_s;
    logic [NT-1:0]     pend_n_s;
    logic              found0_s;
    logic              found1_s;
    logic [EW-1:0]     idx0_s;
    logic [EW-1:0]     idx1_s;
    logic              h0_bub_s;
    logic              h1_bub_s;
    logic              h0_done_s;
    logic              h1_done_s;
    logic              h0_grant_s;
    logic              h1_grant_s;
    logic              stall_a_s;
    logic              stall_b_s;
    logic              h0_valid_n_s;
    logic              h1_valid_n_s;
    logic [INST_W-1:0] h0_inst_n_s;
    logic [INST_W-1:0] h1_inst_n_s;

    // Entries granted last cycle are still flagged empty by the RS, so mask them.
    assign avail0_s = rs_empty & ~pend_r;
    assign avail1_s = avail0_s & ~oh0_s;

    rs_pick #(.N_CX(N_CX), .N_SP(N_SP), .N_FP(N_FP)) u_pick_h0 (
        .control (h0_inst_r[1:0]),
        .avail   (avail0_s),
        .found   (found0_s),
        .idx     (idx0_s),
        .onehot  (oh0_s)
    );

    rs_pick #(.N_CX(N_CX), .N_SP(N_SP), .N_FP(N_FP)) u_pick_h1 (
        .control (h1_inst_r[1:0]),
        .avail   (avail1_s),
        .found   (found1_s),
        .idx     (idx1_s),
        .onehot  (oh1_s)
    );

    // Per-slot outcome; H1 may only go once H0 has gone or is empty.
    always_comb begin
        h0_bub_s   = (h0_inst_r[1:0] == CTRL_BUBBLE);
        h1_bub_s   = (h1_inst_r[1:0] == CTRL_BUBBLE);
        h0_grant_s = h0_valid_r & ~h0_bub_s & found0_s;
        h0_done_s  = ~h0_valid_r | h0_bub_s | found0_s;
        h1_grant_s = h1_valid_r & h0_done_s & ~h1_bub_s & found1_s;
        h1_done_s  = ~h1_valid_r | (h0_done_s & (h1_bub_s | found1_s));
        stall_a_s  = ~h0_done_s;
        stall_b_s  = h1_valid_r & ~h1_bub_s & ~h1_done_s;
        in_ready   = ~reset & ~flush & h0_done_s & h1_done_s;
        pend_n_s   = (h0_grant_s ? oh0_s : {NT{1'b0}}) | (h1_grant_s ? oh1_s : {NT{1'b0}});
    end

    // Residual handling and compaction of the incoming decode pair.
    always_comb begin
        h0_valid_n_s = h0_valid_r;
        h0_inst_n_s  = h0_inst_r;
        h1_valid_n_s = h1_valid_r;
        h1_inst_n_s  = h1_inst_r;
        if (!h0_done_s) begin
            h0_valid_n_s = h0_valid_r;
            h1_valid_n_s = h1_valid_r;
        end else if (!h1_done_s) begin
            h0_valid_n_s = 1'b1;
            h0_inst_n_s  = h1_inst_r;
            h1_valid_n_s = 1'b0;
            h1_inst_n_s  = '0;
        end else if (in_valid_a) begin
            h0_valid_n_s = 1'b1;
            h0_inst_n_s  = in_inst_a;
            h1_valid_n_s = in_valid_b;
            h1_inst_n_s  = in_valid_b ? in_inst_b : {INST_W{1'b0}};
        end else if (in_valid_b) begin
            h0_valid_n_s = 1'b1;
            h0_inst_n_s  = in_inst_b;
            h1_valid_n_s = 1'b0;
            h1_inst_n_s  = '0;
        end else begin
            h0_valid_n_s = 1'b0;
            h0_inst_n_s  = '0;
            h1_valid_n_s = 1'b0;
            h1_inst_n_s  = '0;
        end
    end

    // Hold slots, registered RS write ports, stall flags and pending-grant mask.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            h0_valid_r    <= 1'b0;
            h0_inst_r     <= '0;
            h1_valid_r    <= 1'b0;
            h1_inst_r     <= '0;
            out_a_valid_r <= 1'b0;
            out_a_entry_r <= '0;
            out_a_data_r  <= '0;
            out_b_valid_r <= 1'b0;
            out_b_entry_r <= '0;
            out_b_data_r  <= '0;
            stall_a_r     <= 1'b0;
            stall_b_r     <= 1'b0;
            pend_r        <= '0;
        end else begin
            h0_valid_r    <= h0_valid_n_s;
            h0_inst_r     <= h0_inst_n_s;
            h1_valid_r    <= h1_valid_n_s;
            h1_inst_r     <= h1_inst_n_s;
            out_a_valid_r <= h0_grant_s;
            out_a_entry_r <= h0_grant_s ? idx0_s : {EW{1'b0}};
            out_a_data_r  <= h0_grant_s ? h0_inst_r[INST_W-1:2] : {PW{1'b0}};
            out_b_valid_r <= h1_grant_s;
            out_b_entry_r <= h1_grant_s ? idx1_s : {EW{1'b0}};
            out_b_data_r  <= h1_grant_s ? h1_inst_r[INST_W-1:2] : {PW{1'b0}};
            stall_a_r     <= stall_a_s;
            stall_b_r     <= stall_b_s;
            pend_r        <= pend_n_s;
        end
    end

    // Stall-cycle counter: survives flush, cleared only by reset, saturates.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_r <= 16'h0000;
        end else if (flush) begin
            stall_cnt_r <= stall_cnt_r;
        end else if ((stall_a_s || stall_b_s) && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'h0001;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign out_a_valid = out_a_valid_r;
    assign out_a_entry = out_a_entry_r;
    assign out_a_data  = out_a_data_r;
    assign out_b_valid = out_b_valid_r;
    assign out_b_entry = out_b_entry_r;
    assign out_b_data  = out_b_data_r;
    assign stall_a     = stall_a_r;
    assign stall_b     = stall_b_r;
    assign stall_cnt   = stall_cnt_r;

endmodule

// File: tb/tb_dispatch_unit_param.sv
// Self-checking bench for dispatch_unit_param: queue-based reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_dispatch_unit_param;

    localparam int INST_W = 78;
    localparam int N_CX   = 2;
    localparam int N_SP   = 2;
    localparam int N_FP   = 2;
    localparam int NT     = N_CX + N_SP + N_FP;
    localparam int EW     = 3;
    localparam int PW     = INST_W - 2;

    localparam logic [1:0] C_BUB = 2'b00;
    localparam logic [1:0] C_CX  = 2'b01;
    localparam logic [1:0] C_FP  = 2'b10;
    localparam logic [1:0] C_SP  = 2'b11;

    typedef logic [INST_W-1:0] inst_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic              in_valid_a;
    logic [INST_W-1:0] in_inst_a;
    logic              in_valid_b;
    logic [INST_W-1:0] in_inst_b;
    logic              in_ready;
    logic [NT-1:0]     rs_empty;
    logic              out_a_valid;
    logic [EW-1:0]     out_a_entry;
    logic [PW-1:0]     out_a_data;
    logic              out_b_valid;
    logic [EW-1:0]     out_b_entry;
    logic [PW-1:0]     out_b_data;
    logic              stall_a;
    logic              stall_b;
    logic [15:0]       stall_cnt;

    always #5 clk = ~clk;

    dispatch_unit_param #(.INST_W(INST_W), .N_CX(N_CX), .N_SP(N_SP), .N_FP(N_FP)) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid_a  (in_valid_a),
        .in_inst_a   (in_inst_a),
        .in_valid_b  (in_valid_b),
        .in_inst_b   (in_inst_b),
        .in_ready    (in_ready),
        .rs_empty    (rs_empty),
        .out_a_valid (out_a_valid),
        .out_a_entry (out_a_entry),
        .out_a_data  (out_a_data),
        .out_b_valid (out_b_valid),
        .out_b_entry (out_b_entry),
        .out_b_data  (out_b_data),
        .stall_a     (stall_a),
        .stall_b     (stall_b),
        .stall_cnt   (stall_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: held instructions in program order plus expected registered outputs.
    inst_t         mq[$];
    logic          m_av = 1'b0;
    logic          m_bv = 1'b0;
    logic [EW-1:0] m_ae = '0;
    logic [EW-1:0] m_be = '0;
    logic [PW-1:0] m_ad = '0;
    logic [PW-1:0] m_bd = '0;
    logic          m_sa = 1'b0;
    logic          m_sb = 1'b0;
    logic [15:0]   m_cnt = 16'h0000;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic inst_t mk(input logic [1:0] c, input logic [PW-1:0] p);
        return {p, c};
    endfunction

    function automatic inst_t rnd_inst();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[INST_W-1:0];
    endfunction

    // Preference list per class, scanned for the first entry still available.
    function automatic int first_free(input logic [1:0] ctrl, input logic [NT-1:0] av);
        int cand[$];
        int r;
        r = -1;
        case (ctrl)
            C_SP: begin
                for (int i = N_SP - 1; i >= 0; i--) cand.push_back(N_CX + i);
                for (int i = N_CX - 1; i >= 0; i--) cand.push_back(i);
            end
            C_CX: for (int i = N_CX - 1; i >= 0; i--) cand.push_back(i);
            C_FP: for (int i = NT - 1; i >= N_CX + N_SP; i--) cand.push_back(i);
            default: ;
        endcase
        for (int k = 0; k < cand.size(); k++)
            if (r < 0 && av[cand[k]]) r = cand[k];
        return r;
    endfunction

    // One cycle: drive inputs mid-cycle, compare every output against the model, advance the model.
    task automatic step(input logic va, input inst_t a, input logic vb, input inst_t b,
                        input logic [NT-1:0] emp, input logic fl, input logic rst);
        logic [NT-1:0] av;
        bit            gv[2];
        int            ge[2];
        bit            st[2];
        inst_t         rem[$];
        bit            blocked;
        bit            rdy;
        int            e;
        @(negedge clk);
        in_valid_a = va;
        in_inst_a  = a;
        in_valid_b = vb;
        in_inst_b  = b;
        rs_empty   = emp;
        flush      = fl;
        reset      = rst;
        #1;
        av = emp;
        if (m_av) av[m_ae] = 1'b0;
        if (m_bv) av[m_be] = 1'b0;
        gv = '{1'b0, 1'b0};
        ge = '{0, 0};
        st = '{1'b0, 1'b0};
        blocked = 1'b0;
        for (int k = 0; k < mq.size(); k++) begin
            if (blocked) begin
                rem.push_back(mq[k]);
                st[k] = (mq[k][1:0] != C_BUB);
            end else if (mq[k][1:0] != C_BUB) begin
                e = first_free(mq[k][1:0], av);
                if (e >= 0) begin
                    gv[k] = 1'b1;
                    ge[k] = e;
                    av[e] = 1'b0;
                end else begin
                    blocked = 1'b1;
                    st[k]   = 1'b1;
                    rem.push_back(mq[k]);
                end
            end
        end
        rdy = !rst && !fl && (rem.size() == 0);

        check("in_ready",    128'(in_ready),    128'(rdy));
        check("out_a_valid", 128'(out_a_valid), 128'(m_av));
        check("out_a_entry", 128'(out_a_entry), 128'(m_ae));
        check("out_a_data",  128'(out_a_data),  128'(m_ad));
        check("out_b_valid", 128'(out_b_valid), 128'(m_bv));
        check("out_b_entry", 128'(out_b_entry), 128'(m_be));
        check("out_b_data",  128'(out_b_data),  128'(m_bd));
        check("stall_a",     128'(stall_a),     128'(m_sa));
        check("stall_b",     128'(stall_b),     128'(m_sb));
        check("stall_cnt",   128'(stall_cnt),   128'(m_cnt));

        if (rst || fl) begin
            mq.delete();
            m_av = 1'b0; m_ae = '0; m_ad = '0;
            m_bv = 1'b0; m_be = '0; m_bd = '0;
            m_sa = 1'b0; m_sb = 1'b0;
            if (rst) m_cnt = 16'h0000;
        end else begin
            m_av = gv[0];
            m_ae = gv[0] ? EW'(ge[0]) : '0;
            m_ad = '0;
            if (gv[0]) m_ad = mq[0][INST_W-1:2];
            m_bv = gv[1];
            m_be = gv[1] ? EW'(ge[1]) : '0;
            m_bd = '0;
            if (gv[1]) m_bd = mq[1][INST_W-1:2];
            m_sa = st[0];
            m_sb = st[1];
            if ((st[0] || st[1]) && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'h0001;
            mq = rem;
            if (rdy) begin
                if (va) mq.push_back(a);
                if (vb) mq.push_back(b);
            end
        end
    endtask

    task automatic idle(input logic [NT-1:0] emp);
        step(1'b0, '0, 1'b0, '0, emp, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, '0, 1'b0, '0, 6'b000000, 1'b0, 1'b1);
    endtask

    logic          r_va, r_vb, r_fl, r_rst;
    logic [NT-1:0] r_emp;

    initial begin
        reset = 1'b1; flush = 1'b0; rs_empty = '0;
        in_valid_a = 1'b0; in_inst_a = '0; in_valid_b = 1'b0; in_inst_b = '0;
        repeat (2) @(posedge clk);

        // Reset state
        do_reset();
        check("rst_ready", 128'(in_ready), 128'(1'b0));
        idle(6'b111111);
        check("rst_cnt", 128'(stall_cnt), 128'(16'h0000));
        check("rst_a_valid", 128'(out_a_valid), 128'(1'b0));

        // Two simple instructions, everything empty
        step(1'b1, mk(C_SP, 76'hA1), 1'b1, mk(C_SP, 76'hB1), 6'b111111, 1'b0, 1'b0);
        check("tp1_ready_load", 128'(in_ready), 128'(1'b1));
        idle(6'b111111);
        check("tp1_ready_next", 128'(in_ready), 128'(1'b1));
        idle(6'b111111);
        check("tp1_a_valid", 128'(out_a_valid), 128'(1'b1));
        check("tp1_a_entry", 128'(out_a_entry), 128'(3'd3));
        check("tp1_b_valid", 128'(out_b_valid), 128'(1'b1));
        check("tp1_b_entry", 128'(out_b_entry), 128'(3'd2));
        check("tp1_a_data",  128'(out_a_data),  128'(76'hA1));
        check("tp1_b_data",  128'(out_b_data),  128'(76'hB1));

        // Only complex entries free: simple falls back to complex
        do_reset();
        step(1'b1, mk(C_SP, 76'hA2), 1'b1, mk(C_CX, 76'hB2), 6'b000011, 1'b0, 1'b0);
        idle(6'b000011);
        idle(6'b000011);
        check("tp2_a_entry", 128'(out_a_entry), 128'(3'd1));
        check("tp2_b_entry", 128'(out_b_entry), 128'(3'd0));
        check("tp2_b_valid", 128'(out_b_valid), 128'(1'b1));

        // Nothing free: FP older stalls, then drains in order
        do_reset();
        step(1'b1, mk(C_FP, 76'hA3), 1'b1, mk(C_SP, 76'hB3), 6'b000000, 1'b0, 1'b0);
        idle(6'b000000);
        check("tp3_ready_stall", 128'(in_ready), 128'(1'b0));
        idle(6'b000000);
        check("tp3_stall_a", 128'(stall_a), 128'(1'b1));
        check("tp3_stall_b", 128'(stall_b), 128'(1'b1));
        check("tp3_cnt1", 128'(stall_cnt), 128'(16'd1));
        idle(6'b000000);
        check("tp3_cnt2", 128'(stall_cnt), 128'(16'd2));
        idle(6'b100000);
        check("tp3_cnt3", 128'(stall_cnt), 128'(16'd3));
        check("tp3_ready_partial", 128'(in_ready), 128'(1'b0));
        idle(6'b000100);
        check("tp3_a_entry5", 128'(out_a_entry), 128'(3'd5));
        check("tp3_a_valid5", 128'(out_a_valid), 128'(1'b1));
        check("tp3_ready_drained", 128'(in_ready), 128'(1'b1));
        idle(6'b000000);
        check("tp3_b_in_a_valid", 128'(out_a_valid), 128'(1'b1));
        check("tp3_b_in_a_entry", 128'(out_a_entry), 128'(3'd2));
        check("tp3_b_in_a_data",  128'(out_a_data),  128'(76'hB3));
        check("tp3_b_valid0",     128'(out_b_valid), 128'(1'b0));

        // Pending mask: RS keeps reporting entry 3 empty after the write
        do_reset();
        step(1'b1, mk(C_SP, 76'hA4), 1'b0, '0, 6'b001000, 1'b0, 1'b0);
        step(1'b1, mk(C_SP, 76'hB4), 1'b0, '0, 6'b001000, 1'b0, 1'b0);
        check("tp4_ready", 128'(in_ready), 128'(1'b1));
        idle(6'b001000);
        check("tp4_first_entry", 128'(out_a_entry), 128'(3'd3));
        idle(6'b001000);
        check("tp4_no_regrant", 128'(out_a_valid), 128'(1'b0));
        check("tp4_stall", 128'(stall_a), 128'(1'b1));
        idle(6'b001000);
        check("tp4_second_grant", 128'(out_a_valid), 128'(1'b1));

        // Bubble older + FP younger
        do_reset();
        step(1'b1, mk(C_BUB, 76'hA5), 1'b1, mk(C_FP, 76'hB5), 6'b111111, 1'b0, 1'b0);
        idle(6'b111111);
        idle(6'b111111);
        check("tp5_a_valid", 128'(out_a_valid), 128'(1'b0));
        check("tp5_b_entry", 128'(out_b_entry), 128'(3'd5));
        check("tp5_stall",   128'({stall_a, stall_b}), 128'(2'b00));

        // Flush with both slots stalled
        do_reset();
        step(1'b1, mk(C_FP, 76'hA6), 1'b1, mk(C_FP, 76'hB6), 6'b000000, 1'b0, 1'b0);
        repeat (3) idle(6'b000000);
        step(1'b1, mk(C_SP, 76'hC6), 1'b0, '0, 6'b111111, 1'b1, 1'b0);
        check("tp6_flush_ready", 128'(in_ready), 128'(1'b0));
        check("tp6_pre_stall", 128'(stall_a), 128'(1'b1));
        idle(6'b000000);
        check("tp6_valids", 128'({out_a_valid, out_b_valid}), 128'(2'b00));
        check("tp6_stalls", 128'({stall_a, stall_b}), 128'(2'b00));
        check("tp6_cnt_kept", 128'(stall_cnt), 128'(16'd3));
        check("tp6_holds_empty", 128'(in_ready), 128'(1'b1));
        do_reset();
        idle(6'b000000);
        check("tp6_cnt_reset", 128'(stall_cnt), 128'(16'd0));

        // Saturation of the stall counter
        do_reset();
        step(1'b1, mk(C_FP, 76'hA7), 1'b0, '0, 6'b000000, 1'b0, 1'b0);
        repeat (65540) idle(6'b000000);
        idle(6'b000000);
        check("sat_cnt", 128'(stall_cnt), 128'(16'hFFFF));

        // Randomized traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            r_va  = 1'($urandom_range(0, 1));
            r_vb  = 1'($urandom_range(0, 1));
            r_fl  = ($urandom_range(0, 24) == 0);
            r_rst = ($urandom_range(0, 299) == 0);
            r_emp = NT'($urandom() & $urandom());
            step(r_va, rnd_inst(), r_vb, rnd_inst(), r_emp, r_fl, r_rst);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dispatch_unit_param.md
Name: dispatch_unit_param

Overview:
- Parametrised, registered successor of the 2-wide combinational dispatcher. Holds up to two decoded instructions in program order and picks a free reservation-station (RS) entry for each from a flat entry space (complex, then simple, then FP).
- Drives registered RS write ports and a ready/valid handshake back to decode. Masks entries granted but not yet reflected in the RS empty bits.
- Sits between decode and the distributed reservation stations.

Parameters:
- INST_W, 78: decoded instruction width; bits [1:0] are the dispatch control, bits [INST_W-1:2] are the payload.
- N_CX, 2: number of complex RS entries.
- N_SP, 2: number of simple RS entries.
- N_FP, 2: number of FP RS entries.
- NT, N_CX+N_SP+N_FP: derived total entry count; not overridable.
- EW, $clog2(NT): derived entry-index width.

Ports:
- clk in 1: single clock.
- reset in 1: synchronous reset, active-high.
- flush in 1: sync pipeline flush.
- in_valid_a in 1: decode slot A valid (older).
- in_inst_a in INST_W: decode slot A instruction.
- in_valid_b in 1: decode slot B valid (younger).
- in_inst_b in INST_W: decode slot B instruction.
- in_ready out 1: both slots accepted this cycle.
- rs_empty in NT: empty bit per flat entry. Complex occupies [0..N_CX-1], simple [N_CX..N_CX+N_SP-1], FP the top entries.
- out_a_valid out 1: registered RS write for the older instruction.
- out_a_entry out EW: target flat entry index.
- out_a_data out INST_W-2: payload.
- out_b_valid, out_b_entry, out_b_data: same three outputs for the younger instruction.
- stall_a out 1: registered; older held instruction could not dispatch.
- stall_b out 1: registered; younger held instruction could not dispatch.
- stall_cnt out 16: saturating count of cycles with stall_a|stall_b.

Behaviour:
- Control codes: 11 simple; 01 complex; 10 FP; 00 bubble. A bubble is consumed without an entry and never stalls.
- Candidate entries per class:
  - Simple: simple entries highest index first, then complex entries highest index first.
  - Complex: complex entries highest index first.
  - FP: FP entries highest index first.
- Availability: avail = rs_empty & ~pend. pend holds the entries named by the currently valid out_a/out_b registers, which covers the one-cycle lag before the RS clears its empty bit.
- Hold slots H0 (older) and H1 (younger), each with a valid bit.
- Each cycle:
  - H0 picks first from avail.
  - H1 picks from avail minus H0's pick, and only if H0 dispatched or was empty. Dispatch is strictly in order; H1 never bypasses H0.
  - Grants register into out_* at the clock edge, so latency is 1 cycle from hold to RS write.
  - Grants landing in H0 drive out_a; grants landing in H1 drive out_b.
- Residual handling:
  - If H0 fails, H0 and H1 both stay.
  - If H0 succeeds and H1 fails, H1 moves to H0 and H1 becomes empty.
  - stall_a and stall_b register the per-slot failures.
- in_ready (combinational) is 1 iff no held instruction remains after this cycle's dispatch. It is 0 while reset is asserted.
- Load on in_ready & (in_valid_a | in_valid_b):
  - A goes to H0 and B goes to H1.
  - If only B is valid, B is compacted into H0.
- Newly loaded instructions are dispatched the following cycle. There is no same-cycle bypass.
- out_a_data and out_b_data are 0 whenever the matching valid is 0.
- flush:
  - Next edge clears H0, H1, out_*_valid, out_*_data, out_*_entry, stall_a and stall_b.
  - Input is not accepted that cycle (in_ready=0).
  - stall_cnt is kept.
- reset: all of the above plus stall_cnt cleared to 0. All outputs are 0 after reset.
- Simultaneous reset and flush: reset wins; both give the same register result apart from stall_cnt.
- All entries empty and not pending, with two simple instructions: H0 gets the top simple entry, H1 gets the next simple entry.
- stall_cnt saturates at 16'hFFFF.

Decomposition:
- dispatch_pkg holds:
  - control-code constants;
  - class enum;
  - functions for class base offsets (CX_BASE=0, SP_BASE=N_CX, FP_BASE=N_CX+N_SP).
- Sub-module rs_pick, instantiated twice:
  - Combinational; parametrised by NT.
  - Inputs: control, avail.
  - Outputs: found, idx (EW), onehot (NT).

Test Plan:
- Defaults, rs_empty=6'b111111, A=simple, B=simple, single cycle:
  - Next cycle in_ready=1.
  - One cycle later out_a_entry=3, out_b_entry=2, both valid.
- rs_empty=6'b000011 (complex only), A=simple, B=complex: out_a_entry=1, out_b_entry=0.
- rs_empty=6'b000000, A=FP, B=simple:
  - stall_a=1 and in_ready=0 repeat.
  - stall_cnt increments per cycle.
  - After rs_empty[5]=1, out_a_entry=5; B dispatches in a later cycle with out_b_valid=0 and out_a_valid=1.
- Pending mask: rs_empty held at 6'b001000 despite the write, two simple instructions over consecutive cycles:
  - Second instruction is not granted entry 3 in the cycle after the first grant.
  - The two grants are never to the same entry in adjacent cycles.
- Bubble A (ctrl 00) plus FP B, all empty: out_a_valid=0, out_b_entry=5, no stall.
- Flush with H0/H1 occupied and stalled: next cycle holds are empty and out_*_valid=0; stall_cnt keeps its value; reset clears it to 0.
